pwm_capture: RTL and testbench

Measures an incoming PWM signal (e.g. a 1 kHz sensor or actuator-feedback PWM) in units of the system clock. Reports high time, period and duty cycle in permille, using a ready/valid handshake. It is the receive-side counterpart of the divided-clock PWM generation path and sits between the board's PWM input pins and the soil-monitoring control logic. Stuck-high and stuck-low conditions are flagged via a timeout.

---
 rtl/pwm_pkg.sv | 13 +
 rtl/pwm_duty_divider.sv | 57 +++++
 rtl/pwm_capture.sv | 113 +++++++++++
 tb/tb_pwm_capture.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared FSM state type and duty-cycle scaling constants for pwm_capture
package pwm_pkg;
  typedef enum logic [2:0] {
    IDLE,
    WAIT_RISE,
    MEAS_HIGH,
    MEAS_LOW,
    DIVIDE,
    HOLD
  } state_t;
  localparam int DUTY_SCALE = 1000;
  localparam int DUTY_W     = 10;
endpackage

// File: rtl/pwm_duty_divider.sv
// pwm_duty_divider: serial restoring divider, one quotient bit per cycle
module pwm_duty_divider #(
  parameter int DIVD_W = 34,
  parameter int DIVS_W = 24,
  parameter int Q_W    = 10
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DIVD_W-1:0] dividend,
  input  logic [DIVS_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [Q_W-1:0]    quotient
);
  localparam int SC_W = $clog2(DIVD_W + 1);
  logic [DIVD_W-1:0] q;
  logic [DIVS_W-1:0] rem, dsr, diff;
  logic [SC_W-1:0]   steps;
  logic [DIVS_W:0]   sh;
  logic              ge;
  // rem < dsr always, so the trial difference fits in DIVS_W bits whenever ge
  always_comb begin
    sh   = {rem, q[DIVD_W-1]};
    ge   = sh[DIVS_W] || (sh[DIVS_W-1:0] >= dsr);
    diff = sh[DIVS_W-1:0] - dsr;
  end
  assign quotient = q[Q_W-1:0];
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      q     <= '0;
      rem   <= '0;
      dsr   <= '0;
      steps <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (abort) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      q     <= dividend;
      rem   <= '0;
      dsr   <= divisor;
      steps <= SC_W'(DIVD_W);
      busy  <= 1'b1;
      done  <= 1'b0;
    end else if (busy) begin
      q     <= {q[DIVD_W-2:0], ge};
      rem   <= ge ? diff : sh[DIVS_W-1:0];
      steps <= steps - SC_W'(1);
      busy  <= steps != SC_W'(1);
      done  <= steps == SC_W'(1);
    end else begin
      done <= 1'b0;
    end
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures PWM high time, period and duty (permille) in clock cycles
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W   = 24,
  parameter int TIMEOUT = 200000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              pwm_in,
  output logic              meas_valid,
  input  logic              meas_ready,
  output logic [CNT_W-1:0]  high_count,
  output logic [CNT_W-1:0]  period_count,
  output logic [DUTY_W-1:0] duty_permille,
  output logic              stuck_high,
  output logic              stuck_low
);
  localparam int DIV_W = CNT_W + DUTY_W;
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  state_t            state_q, state_d;
  logic [2:0]        sync_q;
  logic              rise, fall, level, to_hit;
  logic [TO_W-1:0]   to_cnt;
  logic [CNT_W-1:0]  cnt;
  logic              ld_cnt, lat_high, lat_period, ld_duty, accept;
  logic              div_busy, div_done;
  logic [DIV_W-1:0]  dividend;
  logic [DUTY_W-1:0] quotient;
  // sync_q[1:0] is the synchronizer, sync_q[2] the edge-detect history
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) sync_q <= '0;
    else sync_q <= {sync_q[1:0], pwm_in};
  always_comb begin
    level  = sync_q[1];
    rise   = sync_q[1] & ~sync_q[2];
    fall   = ~sync_q[1] & sync_q[2];
    to_hit = !(rise || fall) && to_cnt == TO_W'(TIMEOUT - 1);
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      to_cnt     <= '0;
      stuck_high <= 1'b0;
      stuck_low  <= 1'b0;
    end else if (!enable || rise || fall) begin
      to_cnt     <= '0;
      stuck_high <= 1'b0;
      stuck_low  <= 1'b0;
    end else begin
      if (to_cnt != TO_W'(TIMEOUT)) to_cnt <= to_cnt + TO_W'(1);
      if (to_hit) begin
        stuck_high <= level;
        stuck_low  <= !level;
      end
    end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = WAIT_RISE;
      WAIT_RISE: state_d = rise ? MEAS_HIGH : WAIT_RISE;
      MEAS_HIGH: state_d = to_hit ? WAIT_RISE : fall ? MEAS_LOW : MEAS_HIGH;
      MEAS_LOW:  state_d = to_hit ? WAIT_RISE : rise ? DIVIDE : MEAS_LOW;
      DIVIDE:    state_d = div_done ? HOLD : DIVIDE;
      HOLD:      state_d = accept ? WAIT_RISE : HOLD;
      default:   state_d = IDLE;
    endcase
    if (!enable) state_d = IDLE;
  end
  always_comb begin
    ld_cnt     = enable && state_q == WAIT_RISE && rise;
    lat_high   = enable && state_q == MEAS_HIGH && fall;
    lat_period = enable && state_q == MEAS_LOW && rise && !div_busy;
    ld_duty    = enable && state_q == DIVIDE && div_done;
    accept     = state_q == HOLD && meas_valid && meas_ready;
    dividend   = DIV_W'(high_count) * DIV_W'(DUTY_SCALE);
  end
  // one counter spans both phases: latched at the fall as high time, at the closing rise as period
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (ld_cnt) cnt <= CNT_W'(1);
    else if (state_q == MEAS_HIGH || state_q == MEAS_LOW) cnt <= cnt + CNT_W'(1);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      high_count    <= '0;
      period_count  <= '0;
      duty_permille <= '0;
      meas_valid    <= 1'b0;
    end else begin
      if (lat_high) high_count <= cnt;
      if (lat_period) period_count <= cnt;
      if (ld_duty) duty_permille <= quotient;
      meas_valid <= enable && (ld_duty || (meas_valid && !accept));
    end
  pwm_duty_divider #(
    .DIVD_W(DIV_W),
    .DIVS_W(CNT_W),
    .Q_W   (DUTY_W)
  ) u_div (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (lat_period),
    .abort   (!enable),
    .dividend(dividend),
    .divisor (cnt),
    .busy    (div_busy),
    .done    (div_done),
    .quotient(quotient)
  );
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: randomized self-checking bench for pwm_capture against an arithmetic reference
module tb_pwm_capture;
  localparam int CNT_W = 16;
  localparam int TO    = 3000;
  localparam int LAT   = CNT_W + 11;
  logic clock = 1'b0;
  logic reset_n, enable, pwm_in, meas_ready, meas_valid, stuck_high, stuck_low;
  logic [CNT_W-1:0] high_count, period_count;
  logic [9:0] duty_permille;
  int n_tests = 0, n_fail = 0, cyc = 0;
  bit gen_on = 0;
  int gen_h, gen_p, gen_ph, last_duty, base, t, t2, a, n0, n1;
  logic [2*CNT_W+9:0] snap;
  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TO)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .pwm_in(pwm_in),
    .meas_valid(meas_valid), .meas_ready(meas_ready), .high_count(high_count),
    .period_count(period_count), .duty_permille(duty_permille),
    .stuck_high(stuck_high), .stuck_low(stuck_low)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  function automatic int duty_ref(input int h, input int p);
    return h * 1000 / p;
  endfunction
  task automatic tick();
    @(posedge clock);
    #1;
    if (gen_on) begin
      gen_ph = (gen_ph + 1) % gen_p;
      pwm_in = gen_ph < gen_h;
    end
  endtask
  task automatic wait_valid(input int budget, output int tv);
    int i = 0;
    while (!meas_valid && i < budget) begin
      tick();
      i++;
    end
    tv = cyc;
    if (!meas_valid) begin
      tv = -1;
      check("valid_timeout", 0, 1);
    end
  endtask
  task automatic resync();
    gen_on = 0;
    pwm_in = 0;
    meas_ready = 0;
    enable = 0;
    repeat (4) tick();
    enable = 1;
    repeat (2) tick();
  endtask
  task automatic measure_one(input int h, input int l, input int rdly);
    int nc, tv;
    logic [2*CNT_W+9:0] s;
    pwm_in = 1;
    repeat (h) tick();
    pwm_in = 0;
    repeat (l) tick();
    pwm_in = 1;
    nc = cyc;
    wait_valid(LAT + 20, tv);
    pwm_in = 0;
    check("latency", tv, nc + 3 + LAT);
    check("high_count", high_count, h);
    check("period_count", period_count, h + l);
    check("duty", duty_permille, duty_ref(h, h + l));
    check("no_stuck_high", stuck_high, 0);
    check("no_stuck_low", stuck_low, 0);
    last_duty = duty_ref(h, h + l);
    s = {high_count, period_count, duty_permille};
    repeat (rdly) begin
      tick();
      check("hold_valid", meas_valid, 1);
      check("hold_data", {high_count, period_count, duty_permille}, s);
    end
    meas_ready = 1;
    tick();
    meas_ready = 0;
    check("accept_clears", meas_valid, 0);
    repeat (3) tick();
  endtask
  initial begin
    reset_n = 0;
    enable = 0;
    pwm_in = 0;
    meas_ready = 0;
    repeat (3) tick();
    check("rst_valid", meas_valid, 0);
    check("rst_high", high_count, 0);
    check("rst_period", period_count, 0);
    check("rst_duty", duty_permille, 0);
    check("rst_stuck_high", stuck_high, 0);
    check("rst_stuck_low", stuck_low, 0);
    reset_n = 1;
    tick();
    enable = 1;
    repeat (TO - 10) tick();
    check("stuck_low_early", stuck_low, 0);
    repeat (20) tick();
    check("stuck_low", stuck_low, 1);
    check("stuck_low_not_high", stuck_high, 0);
    measure_one(2000, 2000, 3);
    measure_one(1, 2, 0);
    for (int k = 0; k < 8; k++)
      measure_one($urandom_range(1, 400), $urandom_range(1, 400), $urandom_range(0, 20));
    pwm_in = 1;
    n0 = cyc;
    while (cyc < n0 + 3 + TO - 1) tick();
    check("stuck_high_early", stuck_high, 0);
    tick();
    check("stuck_high", stuck_high, 1);
    check("stuck_high_no_valid", meas_valid, 0);
    pwm_in = 0;
    repeat (2) tick();
    check("stuck_high_held", stuck_high, 1);
    tick();
    check("stuck_high_cleared", stuck_high, 0);
    measure_one(40, 60, 2);
    pwm_in = 1;
    repeat (30) tick();
    pwm_in = 0;
    repeat (50) tick();
    pwm_in = 1;
    n1 = cyc;
    while (cyc < n1 + 3 + 5) tick();
    enable = 0;
    tick();
    check("abort_valid", meas_valid, 0);
    check("abort_keep_high", high_count, 30);
    check("abort_keep_period", period_count, 80);
    check("abort_keep_duty", duty_permille, last_duty);
    pwm_in = 0;
    repeat (40) tick();
    enable = 1;
    repeat (LAT + 20) tick();
    check("no_late_valid", meas_valid, 0);
    pwm_in = 1;
    repeat (20) tick();
    pwm_in = 0;
    repeat (20) tick();
    pwm_in = 1;
    wait_valid(LAT + 20, t);
    check("pre_rst_valid", meas_valid, 1);
    #2 reset_n = 0;
    #1;
    check("hold_rst_valid", meas_valid, 0);
    check("hold_rst_high", high_count, 0);
    check("hold_rst_period", period_count, 0);
    check("hold_rst_duty", duty_permille, 0);
    check("hold_rst_stuck_high", stuck_high, 0);
    check("hold_rst_stuck_low", stuck_low, 0);
    pwm_in = 0;
    repeat (2) tick();
    reset_n = 1;
    tick();
    resync();
    meas_ready = 1;
    gen_h = 250;
    gen_p = 1000;
    gen_ph = 0;
    pwm_in = 1;
    base = cyc;
    gen_on = 1;
    for (int k = 0; k < 3; k++) begin
      wait_valid(2500, t);
      check("b2b_high", high_count, 250);
      check("b2b_period", period_count, 1000);
      check("b2b_duty", duty_permille, 250);
      check("b2b_align", (t - 3 - LAT - base) % gen_p, 0);
      tick();
      check("b2b_accept", meas_valid, 0);
    end
    resync();
    gen_h = 300;
    gen_p = 1000;
    gen_ph = 0;
    pwm_in = 1;
    base = cyc;
    gen_on = 1;
    wait_valid(2500, t);
    check("rl_high", high_count, 300);
    check("rl_period", period_count, 1000);
    check("rl_duty", duty_permille, 300);
    snap = {high_count, period_count, duty_permille};
    repeat (5000) begin
      tick();
      check("rl_valid_stable", meas_valid, 1);
      check("rl_data_stable", {high_count, period_count, duty_permille}, snap);
    end
    a = cyc;
    meas_ready = 1;
    tick();
    meas_ready = 0;
    check("rl_accept", meas_valid, 0);
    wait_valid(2500, t2);
    check("rl2_high", high_count, 300);
    check("rl2_period", period_count, 1000);
    check("rl2_duty", duty_permille, 300);
    check("rl2_align", (t2 - 3 - LAT - base) % gen_p, 0);
    check("rl2_fresh_rise", (t2 - LAT - gen_p) >= a + 2, 1);
    resync();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
